// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: widths, ALU op codes,
// flag bit positions and the arbiter FSM state type.
package alu_arb_pkg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 2;
    localparam int FLAG_W = 4;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_ctrl_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU (ADD/SUB/AND/OR) producing {N,Z,C,V} flags.
// Carry is bit 32 of the 33-bit unsigned add/sub; logic ops clear C and V.
module alu_arbiter_alu
    import alu_arb_pkg::*;
(
    input  logic [DATA_W-1:0] srca,
    input  logic [DATA_W-1:0] srcb,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flag
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [DATA_W-1:0] r_s;
    logic        [DATA_W:0]   wide;
    logic                     carry;
    logic                     ovf;

    function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] r);
        return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b,
                                     input logic signed [DATA_W-1:0] r);
        return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction

    function automatic logic [FLAG_W-1:0] pack_flags(input logic [DATA_W-1:0] r,
                                                     input logic c,
                                                     input logic v);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_N] = r[DATA_W-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    always_comb begin
        a_s   = $signed(srca);
        b_s   = $signed(srcb);
        wide  = '0;
        r_s   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (ctrl)
            ALU_ADD: begin
                wide  = {1'b0, srca} + {1'b0, srcb};
                r_s   = $signed(wide[DATA_W-1:0]);
                carry = wide[DATA_W];
                ovf   = add_ovf(a_s, b_s, r_s);
            end
            ALU_SUB: begin
                // C is the raw bit 32, i.e. a borrow indicator (set when srca < srcb)
                wide  = {1'b0, srca} - {1'b0, srcb};
                r_s   = $signed(wide[DATA_W-1:0]);
                carry = wide[DATA_W];
                ovf   = sub_ovf(a_s, b_s, r_s);
            end
            ALU_AND: r_s = a_s & b_s;
            ALU_OR:  r_s = a_s | b_s;
            default: r_s = '0;
        endcase
        result = $unsigned(r_s);
        flag   = pack_flags($unsigned(r_s), carry, ovf);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; one op in flight (IDLE->EXEC->RESP).
// Optional sticky flag register enabled by defining ALU_ARB_FLAGREG_EN.
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_srca,
    input  logic [31:0] req0_srcb,
    input  logic [1:0]  req0_ctrl,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_srca,
    input  logic [31:0] req1_srcb,
    input  logic [1:0]  req1_ctrl,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flag,
    output logic [3:0]  flags_q
);

    state_e             state;
    state_e             state_nxt;
    logic               last_grant;
    logic               grant_vld;
    logic               grant_id;
    logic               vld_p0;
    logic               vld_p1;

    logic [DATA_W-1:0]  srca_p0;
    logic [DATA_W-1:0]  srcb_p0;
    logic [CTRL_W-1:0]  ctrl_p0;
    logic               id_p0;

    logic [DATA_W-1:0]  alu_result;
    logic [FLAG_W-1:0]  alu_flag;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_vld) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant only in IDLE; on a tie the requester that was not served last wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
        req0_ready = grant_vld && !grant_id;
        req1_ready = grant_vld &&  grant_id;
        vld_p0     = (state == S_EXEC);
        vld_p1     = (state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset)          last_grant <= 1'b1;
        else if (grant_vld) last_grant <= grant_id;
    end

    // ---- stage p0: operands captured on the request handshake ----
    always_ff @(posedge clk) begin
        if (grant_vld) begin
            srca_p0 <= grant_id ? req1_srca : req0_srca;
            srcb_p0 <= grant_id ? req1_srcb : req0_srcb;
            ctrl_p0 <= grant_id ? req1_ctrl : req0_ctrl;
            id_p0   <= grant_id;
        end
    end

    alu_arbiter_alu u_alu (
        .srca   (srca_p0),
        .srcb   (srcb_p0),
        .ctrl   (ctrl_p0),
        .result (alu_result),
        .flag   (alu_flag)
    );

    // ---- stage p1: response registers, loaded only at the end of EXEC ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flag   <= '0;
        end else if (vld_p0) begin
            rsp_id     <= id_p0;
            rsp_result <= alu_result;
            rsp_flag   <= alu_flag;
        end
    end

    assign rsp_valid = vld_p1;

`ifdef ALU_ARB_FLAGREG_EN
    always_ff @(posedge clk) begin
        if (reset)                       flags_q <= '0;
        else if (rsp_valid && rsp_ready) flags_q <= rsp_flag;
    end
`else
    assign flags_q = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, multi-cycle corner cases,
// and randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_srca, req0_srcb;
    logic [1:0]  req0_ctrl;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_srca, req1_srcb;
    logic [1:0]  req1_ctrl;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flag;
    logic [3:0]  flags_q;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_srca  (req0_srca),
        .req0_srcb  (req0_srcb),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_srca  (req1_srca),
        .req1_srcb  (req1_srcb),
        .req1_ctrl  (req1_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference ALU from arithmetic definitions: returns {N,Z,C,V, result}
    function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] c);
        longint sa, sb, ua, ub, s;
        longint lim;
        logic [31:0] r;
        bit cf, vf;
        sa = $signed(a); sb = $signed(b);
        ua = a; ub = b;
        lim = 64'sd2147483647;
        cf = 0; vf = 0; r = '0;
        case (c)
            2'd0: begin
                r  = a + b;
                cf = (ua + ub) > 64'sd4294967295;
                s  = sa + sb;
                vf = (s > lim) || (s < -lim - 1);
            end
            2'd1: begin
                r  = a - b;
                cf = (a < b);
                s  = sa - sb;
                vf = (s > lim) || (s < -lim - 1);
            end
            2'd2: r = a & b;
            default: r = a | b;
        endcase
        return {r[31], (r == 32'd0), cf, vf, r};
    endfunction

    // Transaction-level model: busy flag, age of the accepted op, expected response.
    bit          m_busy = 0;
    int          m_age  = 0;
    bit          m_last = 1;
    bit          m_id   = 0;
    logic [31:0] m_res  = '0;
    logic [3:0]  m_flg  = '0;
    logic [3:0]  m_fq   = '0;

    initial begin
        int          s_g;
        bit          s_rst, s_rr, have_s;
        logic [31:0] s_a, s_b;
        logic [1:0]  s_c;
        bit          rsp_exp;
        have_s = 0; s_g = -1; s_rst = 0; s_rr = 0; s_a = '0; s_b = '0; s_c = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (have_s) begin
                if (s_rst) begin
                    m_busy = 0; m_last = 1; m_fq = '0;
                end else if (s_g >= 0) begin
                    m_busy = 1; m_age = 0; m_last = (s_g == 1); m_id = (s_g == 1);
                    {m_flg, m_res} = ref_alu(s_a, s_b, s_c);
                end else if (m_busy) begin
                    if (m_age == 0) m_age = 1;
                    else if (s_rr) begin
                        m_busy = 0;
`ifdef ALU_ARB_FLAGREG_EN
                        m_fq = m_flg;
`endif
                    end
                end
            end
            s_g = -1;
            if (!m_busy) begin
                if (req0_valid && req1_valid) s_g = m_last ? 0 : 1;
                else if (req0_valid)          s_g = 0;
                else if (req1_valid)          s_g = 1;
            end
            rsp_exp = m_busy && (m_age >= 1);
            chk("mon_req0_ready", req0_ready, s_g == 0);
            chk("mon_req1_ready", req1_ready, s_g == 1);
            chk("mon_rsp_valid", rsp_valid, rsp_exp);
            if (rsp_exp) begin
                chk("mon_rsp_id", rsp_id, m_id);
                chk("mon_rsp_result", rsp_result, m_res);
                chk("mon_rsp_flag", rsp_flag, m_flg);
            end
            chk("mon_flags_q", flags_q, m_fq);
            s_rst = reset; s_rr = rsp_ready;
            s_a = (s_g == 1) ? req1_srca : req0_srca;
            s_b = (s_g == 1) ? req1_srcb : req0_srcb;
            s_c = (s_g == 1) ? req1_ctrl : req0_ctrl;
            have_s = 1;
        end
    end

    task automatic set_req(input int n, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] c);
        if (n == 0) begin
            req0_valid = v; req0_srca = a; req0_srcb = b; req0_ctrl = c;
        end else begin
            req1_valid = v; req1_srca = a; req1_srcb = b; req1_ctrl = c;
        end
    endtask

    task automatic drain();
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic op_run(input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] c, output logic [31:0] res,
                          output logic [3:0] flg, output logic id, output int lat);
        int k;
        set_req(n, 1'b1, a, b, c);
        k = 0;
        forever begin
            @(negedge clk);
            if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) break;
            k++;
            if (k > 20) break;
            @(posedge clk); #1;
        end
        chk("grant_wait", (k <= 20), 1'b1);
        @(posedge clk); #1;
        set_req(n, 1'b0, a, b, c);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        res = rsp_result; flg = rsp_flag; id = rsp_id;
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  c;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res;
        logic [3:0]  flg;
        logic        id;
        int          lat;
        int          order[$];
        int          when[$];
        int          cyc;
        bit          saw;

        tbl[0] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 4'b0110};
        tbl[1] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'b1001};
        tbl[2] = '{0, 32'h0000_0003, 32'h0000_0005, 2'b01, 32'hFFFF_FFFE, 4'b1010};
        tbl[3] = '{1, 32'h0000_0000, 32'h0000_0000, 2'b11, 32'h0000_0000, 4'b0100};
        tbl[4] = '{0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10, 32'h0000_0000, 4'b0100};
        tbl[5] = '{1, 32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 4'b0001};
        tbl[6] = '{0, 32'h1234_5678, 32'h0F0F_0F0F, 2'b11, 32'h1F3F_5F7F, 4'b0000};
        tbl[7] = '{1, 32'h0000_0005, 32'h0000_0005, 2'b01, 32'h0000_0000, 4'b0100};

        reset = 1; rsp_ready = 1;
        req0_valid = 0; req0_srca = '0; req0_srcb = '0; req0_ctrl = '0;
        req1_valid = 0; req1_srca = '0; req1_srcb = '0; req1_ctrl = '0;
        @(posedge clk); #1;
        mon_en = 1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_id", rsp_id, 1'b0);
        chk("reset_rsp_result", rsp_result, 32'h0);
        chk("reset_rsp_flag", rsp_flag, 4'h0);
        chk("reset_flags_q", flags_q, 4'h0);
        @(posedge clk); #1;
        reset = 0;

        // Directed table: single requester at a time, latency and flags checked.
        for (int i = 0; i < 8; i++) begin
            op_run(tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].c, res, flg, id, lat);
            chk("tbl_latency", lat, 2);
            chk("tbl_rsp_id", id, tbl[i].n[0]);
            chk("tbl_rsp_result", res, tbl[i].res);
            chk("tbl_rsp_flag", flg, tbl[i].flg);
`ifdef ALU_ARB_FLAGREG_EN
            chk("tbl_flags_q", flags_q, tbl[i].flg);
`else
            chk("tbl_flags_q_zero", flags_q, 4'h0);
`endif
        end
        drain();

        // Both requesters continuously valid: alternate grants, one every 3 cycles.
        pulse_reset();
        set_req(0, 1'b1, 32'd1, 32'd2, 2'b00);
        set_req(1, 1'b1, 32'd9, 32'd4, 2'b01);
        cyc = 0;
        while (order.size() < 4 && cyc < 40) begin
            @(negedge clk);
            if (req0_ready) begin order.push_back(0); when.push_back(cyc); end
            if (req1_ready) begin order.push_back(1); when.push_back(cyc); end
            @(posedge clk); #1;
            cyc++;
        end
        chk("rr_grant_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) begin
            chk("rr_grant_order", order[i], i % 2);
            if (i > 0) chk("rr_issue_interval", when[i] - when[i-1], 3);
        end
        drain();

        // Back-pressure: response held stable, no new grant while blocked.
        rsp_ready = 0;
        set_req(0, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10);
        cyc = 0;
        do begin
            @(negedge clk);
            saw = req0_ready;
            @(posedge clk); #1;
            cyc++;
        end while (!saw && cyc < 20);
        chk("bp_grant_seen", saw, 1'b1);
        req0_valid = 0;
        set_req(1, 1'b1, 32'd7, 32'd8, 2'b00);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 20);
        chk("bp_rsp_seen", rsp_valid, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1'b1);
            chk("bp_hold_result", rsp_result, 32'h0);
            chk("bp_hold_flag", rsp_flag, 4'b0100);
            chk("bp_no_ready", req1_ready, 1'b0);
            @(posedge clk); #1;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_grant_after_rsp", req1_ready, 1'b1);
        @(posedge clk); #1;
        drain();

        // Reset while req0's SUB is in EXEC: op discarded, req0 wins the next tie.
        set_req(0, 1'b1, 32'd10, 32'd4, 2'b01);
        cyc = 0;
        do begin
            @(negedge clk);
            saw = req0_ready;
            @(posedge clk); #1;
            cyc++;
        end while (!saw && cyc < 20);
        chk("rx_grant_seen", saw, 1'b1);
        req0_valid = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        saw = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) saw = 1;
            @(posedge clk); #1;
        end
        chk("rx_no_response", saw, 1'b0);
        set_req(0, 1'b1, 32'd1, 32'd1, 2'b00);
        set_req(1, 1'b1, 32'd2, 32'd2, 2'b00);
        @(negedge clk);
        chk("rx_tie_req0_ready", req0_ready, 1'b1);
        chk("rx_tie_req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        drain();

        // Randomized traffic, checked cycle by cycle by the reference model.
        for (int i = 0; i < 600; i++) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req0_srca  = pick(); req0_srcb = pick(); req0_ctrl = 2'($urandom_range(0, 3));
            req1_valid = ($urandom_range(0, 99) < 60);
            req1_srca  = pick(); req1_srcb = pick(); req1_ctrl = 2'($urandom_range(0, 3));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        reset = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have no parameters; data width fixed at 32, control width 2, flag width 4.
REQ-002 SHALL have: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have per requester n in {0,1}: reqn_valid input 1 request present; reqn_ready output 1 request accepted this cycle.
REQ-005 SHALL have per requester n: reqn_srca input 32, reqn_srcb input 32 operands; reqn_ctrl input 2 operation (00 ADD, 01 SUB, 10 AND, 11 OR).
REQ-006 SHALL have: rsp_valid output 1; rsp_ready input 1; rsp_id output 1 requester index; rsp_result output 32; rsp_flag output 4 {N,Z,C,V}.
REQ-007 SHALL have: flags_q output 4 sticky status register {N,Z,C,V}.

Function
REQ-008 SHALL share one ALU instance between two requesters; one operation in flight at a time.
REQ-009 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; EXEC lasts exactly one cycle; RESP holds until rsp_valid && rsp_ready.
REQ-010 SHALL, in IDLE only, grant combinationally: single valid requester wins; both valid -> requester not equal to last_grant wins.
REQ-011 SHALL drive reqn_ready=1 only in IDLE for the granted requester; ready SHALL be 0 in EXEC and RESP.
REQ-012 SHALL, on handshake (valid && ready), latch srca, srcb, ctrl, requester index into operand registers and set last_grant to that index.
REQ-013 SHALL present latched operands to the ALU during EXEC and register ALU result and flags into rsp_result/rsp_flag at end of EXEC.
REQ-014 SHALL assert rsp_valid in the cycle after EXEC; handshake in cycle T gives rsp_valid in T+2; minimum issue interval 3 cycles.
REQ-015 SHALL hold rsp_valid, rsp_id, rsp_result, rsp_flag stable while rsp_valid && !rsp_ready.
REQ-016 SHALL return to IDLE in the cycle after the response handshake; a new grant is possible that IDLE cycle (no combinational ready from rsp_ready).
REQ-017 SHALL not reorder or drop requests; a requester whose valid falls before handshake is simply not served.
REQ-018 Flag semantics SHALL follow the ALU: ADD/SUB C = bit 32 of 33-bit result, V = signed overflow; AND/OR C=V=0; Z = result==0; N = result[31].

Reset
REQ-019 SHALL, on reset, force IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flag=0, flags_q=0, last_grant=1 (requester 0 wins first tie).
REQ-020 Reset SHALL dominate in any state; an operation in EXEC or RESP is discarded with no response.

Configuration
REQ-021 With ALU_ARB_FLAGREG_EN defined, flags_q SHALL load rsp_flag on every response handshake and hold otherwise.
REQ-022 Without ALU_ARB_FLAGREG_EN, flags_q SHALL be constant 0 and no flag register SHALL be synthesized.

Structure
REQ-023 Shared package alu_arb_pkg SHALL hold ALU control encodings, flag bit indices (N=3,Z=2,C=1,V=0) and the FSM state type.
REQ-024 The existing ALU module SHALL be the one sub-module, instantiated once, fed only from operand registers.

Verification
REQ-025 Reset, req0 ADD 0xFFFFFFFF+0x00000001 -> rsp_valid at T+2, rsp_id=0, rsp_result=0, rsp_flag=4'b0110.
REQ-026 req1 ADD 0x7FFFFFFF+0x00000001 -> rsp_result=0x80000000, rsp_flag=4'b1001.
REQ-027 Both valid continuously, 4 ops -> grant order 0,1,0,1; ready never asserted outside IDLE.
REQ-028 rsp_ready held low 5 cycles on AND 0xF0F0F0F0 & 0x0F0F0F0F -> rsp_valid held, rsp_result=0, rsp_flag=4'b0100 stable, no new ready.
REQ-029 reset asserted during EXEC of req0 SUB -> next cycle IDLE, rsp_valid=0, no response for that op; next tie grants req0.
REQ-030 ALU_ARB_FLAGREG_EN defined, SUB 3-5 then OR 0|0 -> flags_q=4'b1010 after first handshake, 4'b0100 after second; undefined -> flags_q=0 throughout.
